// File: rtl/uart_pkg.sv
// Shared definitions for the UART host-side transmit feeder.
package uart_pkg;

  // Width of one UART data byte.
  localparam int UART_DW = 8;

  // Feeder FSM: IDLE -> LOAD (xmit pulse) -> WAIT_BUSY (done low) -> WAIT_DONE (done high).
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } xfeed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered count and full/empty derived from it.
// The head entry is readable combinationally so the consumer can capture it on its pop edge.
module sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  // Pushes into a full FIFO and pops from an empty one are ignored.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_xmit_feeder.sv
// Buffers bytes from system logic and issues them one at a time to the UART
// transmitter, pacing each request on the transmitter's done indication.
module uart_xmit_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               wr_enH,
  input  logic [UART_DW-1:0] wr_dataH,
  output logic               fullH,
  output logic               emptyH,
  output logic [AW:0]        countH,
  output logic               overflowH,
  input  logic               clr_errH,
  output logic               xmitH,
  output logic [UART_DW-1:0] xmit_dataH,
  input  logic               xmit_doneH,
  output logic               busyH
);

  xfeed_state_t       state_q, state_d;
  logic               xmit_q, xmit_d;
  logic [UART_DW-1:0] data_q, data_d;
  logic               ovf_q;
  logic               fifo_pop;
  logic [UART_DW-1:0] fifo_head;

  sync_fifo #(
    .DW    (UART_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .srst    (sys_rst),
    .push_i  (wr_enH),
    .wdata_i (wr_dataH),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fullH),
    .empty_o (emptyH),
    .count_o (countH)
  );

  // Sticky overflow: a rejected push sets it, and setting beats a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q <= 1'b0;
    end else if (wr_enH && fullH) begin
      ovf_q <= 1'b1;
    end else if (clr_errH) begin
      ovf_q <= 1'b0;
    end
  end

  // FSM state plus registered request and data toward the transmitter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      xmit_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      xmit_q  <= xmit_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: pop and launch from IDLE, then wait for done low followed by done high.
  always_comb begin
    state_d  = state_q;
    xmit_d   = 1'b0;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!emptyH) begin
          state_d  = LOAD;
          xmit_d   = 1'b1;
          data_d   = fifo_head;
          fifo_pop = 1'b1;
        end
      end
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!xmit_doneH) state_d = WAIT_DONE;
      WAIT_DONE: if (xmit_doneH)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign xmitH      = xmit_q;
  assign xmit_dataH = data_q;
  assign busyH      = (state_q != IDLE);
  assign overflowH  = ovf_q;

endmodule
